// File: rtl/audio_pkg.sv
// Shared definitions for the audio scheduler: command codes, FSM states and
// the default number of sound sources.
package audio_pkg;

  localparam int N_SRC_DEFAULT = 4;

  localparam logic [7:0] CMD_STOP    = 8'h00;
  localparam logic [3:0] CMD_ONESHOT = 4'h1;
  localparam logic [3:0] CMD_LOOP    = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_PLAY,
    ST_GAP
  } state_e;

endpackage

// File: rtl/audio_prio_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module audio_prio_enc
  import audio_pkg::*;
#(
  parameter int N = N_SRC_DEFAULT
) (
  input  logic [N-1:0]         i_req,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    // Scanning downwards lets the lowest set index overwrite any higher one.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = ($clog2(N))'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_scheduler.sv
// Command-driven fixed-priority scheduler granting one sound source at a time.
// Define AUDIO_SCHED_FINISH_EN to let a stopped source play until it reports done.
module audio_scheduler
  import audio_pkg::*;
#(
  parameter int N_SRC      = N_SRC_DEFAULT,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  input  logic [7:0]               i_cmd_data,
  input  logic [N_SRC-1:0]         i_src_pulse,
  input  logic [N_SRC-1:0]         i_src_done,
  output logic [N_SRC-1:0]         o_src_enable,
  output logic                     o_pulse,
  output logic [$clog2(N_SRC)-1:0] o_grant_id,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
`ifdef AUDIO_SCHED_FINISH_EN
  localparam bit STOP_CUTS = 1'b0;
`else
  localparam bit STOP_CUTS = 1'b1;
`endif

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   pending_q, pending_d, loop_q, loop_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]         play_cnt_q, play_cnt_d;
  logic               pulse_q, pulse_d, err_q, err_d;

  logic [N_SRC-1:0]   pending_upd, loop_upd, lower_mask;
  logic [IDX_W-1:0]   win_idx, cmd_idx;
  logic [3:0]         cmd_hi, cmd_lo;
  logic               win_valid, stop_cmd, cmd_in_range, active, play_over;

  assign cmd_hi       = i_cmd_data[7:4];
  assign cmd_lo       = i_cmd_data[3:0];
  assign cmd_idx      = cmd_lo[IDX_W-1:0];
  assign cmd_in_range = 32'(cmd_lo) < N_SRC;
  assign active       = (state_q == ST_GRANT) || (state_q == ST_PLAY);

  // The command is folded into pending/loop before any FSM decision sees them.
  always_comb begin
    pending_upd = pending_q;
    loop_upd    = loop_q;
    stop_cmd    = 1'b0;
    err_d       = 1'b0;
    if (i_cmd_valid) begin
      if (i_cmd_data == CMD_STOP) begin
        pending_upd = '0;
        loop_upd    = '0;
        stop_cmd    = 1'b1;
      end else if (cmd_in_range && (cmd_hi == CMD_ONESHOT || cmd_hi == CMD_LOOP)) begin
        if (cmd_hi == CMD_LOOP) loop_upd[cmd_idx] = 1'b1;
        if (!(active && cmd_idx == grant_q)) pending_upd[cmd_idx] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) lower_mask[i] = i < int'(grant_q);
  end

  audio_prio_enc #(.N(N_SRC)) u_prio_enc (
    .i_req   (pending_upd),
    .o_idx   (win_idx),
    .o_valid (win_valid)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_upd;
    loop_d     = loop_upd;
    grant_d    = grant_q;
    gap_cnt_d  = gap_cnt_q;
    play_cnt_d = play_cnt_q;
    play_over  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d            = ST_GRANT;
          grant_d            = win_idx;
          pending_d[win_idx] = 1'b0;
        end
      end
      ST_GRANT: begin
        state_d    = ST_PLAY;
        play_cnt_d = '0;
      end
      ST_PLAY: begin
        if (play_cnt_q != 2'd2) play_cnt_d = play_cnt_q + 2'd1;
        // Done is still high from idle when enable rises, so ignore it for two cycles.
        play_over = (|(pending_upd & lower_mask))
                  || (STOP_CUTS && stop_cmd)
                  || (i_src_done[grant_q] && play_cnt_q == 2'd2);
        if (play_over) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          if (loop_upd[grant_q]) pending_d[grant_q] = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pulse_d = (state_d == ST_PLAY) ? i_src_pulse[grant_d] : 1'b0;

  // NOTE: state uses non-blocking assignments and every flop has an async reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      loop_q     <= '0;
      grant_q    <= '0;
      gap_cnt_q  <= '0;
      play_cnt_q <= '0;
      pulse_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      loop_q     <= loop_d;
      grant_q    <= grant_d;
      gap_cnt_q  <= gap_cnt_d;
      play_cnt_q <= play_cnt_d;
      pulse_q    <= pulse_d;
      err_q      <= err_d;
    end
  end

  assign o_src_enable = (state_q == ST_PLAY) ? (N_SRC'(1) << grant_q) : '0;
  assign o_pulse      = pulse_q;
  assign o_grant_id   = grant_q;
  assign o_busy       = state_q != ST_IDLE;
  assign o_err        = err_q;

endmodule

// File: tb/tb_audio_scheduler.sv
// Scoreboard bench: expected enable/err events are queued when stimulus is
// driven and compared (value and cycle) as the DUT produces them.
module tb_audio_scheduler;

  localparam int N_SRC   = 4;
  localparam int GAP     = 1000;
  localparam int EV_RISE = 1;
  localparam int EV_FALL = 2;
  localparam int EV_ERR  = 3;

  logic             i_clk;
  logic             i_rst;
  logic             i_cmd_valid;
  logic [7:0]       i_cmd_data;
  logic [N_SRC-1:0] i_src_pulse;
  logic [N_SRC-1:0] i_src_done;
  logic [N_SRC-1:0] o_src_enable;
  logic             o_pulse;
  logic [1:0]       o_grant_id;
  logic             o_busy;
  logic             o_err;

  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [31:0]      sb[$];
  logic [N_SRC-1:0] prev_en = '0;

  audio_scheduler #(.N_SRC(N_SRC), .GAP_CYCLES(GAP)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd_data   (i_cmd_data),
    .i_src_pulse  (i_src_pulse),
    .i_src_done   (i_src_done),
    .o_src_enable (o_src_enable),
    .o_pulse      (o_pulse),
    .o_grant_id   (o_grant_id),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: cycle %0d reached, required finish before it", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int first_set(input logic [N_SRC-1:0] v);
    int r = 0;
    for (int i = N_SRC - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic expect_ev(input int c, input int kind, input int id);
    sb.push_back({c[23:0], kind[3:0], id[3:0]});
  endtask

  task automatic log_event(input int kind, input int id);
    logic [31:0] ev;
    logic [31:0] exp;
    ev = {cyc[23:0], kind[3:0], id[3:0]};
    if (sb.size() == 0) begin
      check("unexpected_event", ev, 32'h0);
    end else begin
      exp = sb.pop_front();
      check("event", ev, exp);
      if (kind == EV_RISE) check("grant_id", 32'(o_grant_id), 32'(exp[3:0]));
    end
  endtask

  // Monitor: turns enable edges and err pulses into cycle-stamped events.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_en = '0;
    end else begin
      if (o_src_enable != prev_en) begin
        check("enable_onehot", 32'($onehot0(o_src_enable)), 32'd1);
        if (prev_en != '0) log_event(EV_FALL, first_set(prev_en));
        if (o_src_enable != '0) log_event(EV_RISE, first_set(o_src_enable));
        prev_en = o_src_enable;
      end
      if (o_err) log_event(EV_ERR, 0);
    end
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge i_clk);
  endtask

  task automatic send(input logic [7:0] b);
    i_cmd_valid = 1'b1;
    i_cmd_data  = b;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_data  = 8'h00;
  endtask

  initial begin
    int t, d, p, q, s;
    logic [7:0] pat;
    i_rst       = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_data  = 8'h10;
    i_src_pulse = '1;
    i_src_done  = '1;
    #1 i_rst = 1'b1;
    repeat (3) tick();
    check("rst_enable", 32'(o_src_enable), 32'h0);
    check("rst_pulse", 32'(o_pulse), 32'h0);
    check("rst_grant", 32'(o_grant_id), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_err", 32'(o_err), 32'h0);
    i_cmd_valid = 1'b0;
    i_src_pulse = '0;
    i_rst       = 1'b0;
    repeat (2) tick();

    // One-shot playback with pulse forwarding and a full gap.
    i_src_done = 4'b1110;
    t = cyc;
    expect_ev(t + 2, EV_RISE, 0);
    send(8'h10);
    wait_until(t + 10);
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      i_src_pulse = {{3{~pat[i]}}, pat[i]};
      tick();
      check("pulse_fwd", 32'(o_pulse), 32'(pat[i]));
    end
    wait_until(t + 50);
    d = cyc;
    expect_ev(d + 1, EV_FALL, 0);
    i_src_done  = 4'b1111;
    i_src_pulse = 4'b1111;
    tick();
    check("gap_busy_first", 32'(o_busy), 32'h1);
    check("gap_pulse", 32'(o_pulse), 32'h0);
    wait_until(d + GAP);
    check("gap_busy_last", 32'(o_busy), 32'h1);
    tick();
    check("idle_after_gap", 32'(o_busy), 32'h0);
    i_src_pulse = '0;

    // Invalid commands, including three back-to-back.
    t = cyc;
    expect_ev(t + 1, EV_ERR, 0);
    send(8'h35);
    wait_until(t + 3);
    t = cyc;
    expect_ev(t + 1, EV_ERR, 0);
    expect_ev(t + 2, EV_ERR, 0);
    expect_ev(t + 3, EV_ERR, 0);
    send(8'h14);
    send(8'h0F);
    send(8'h24);
    wait_until(t + 8);
    check("invalid_no_grant", 32'(o_busy), 32'h0);

    // Back-to-back requests: source 2 granted, then preempted by source 1 at once.
    t = cyc;
    expect_ev(t + 2, EV_RISE, 2);
    expect_ev(t + 3, EV_FALL, 2);
    expect_ev(t + 1005, EV_RISE, 1);
    expect_ev(t + 1008, EV_FALL, 1);
    send(8'h12);
    send(8'h11);
    wait_until(t + 1008 + GAP + 5);
    check("b2b_idle", 32'(o_busy), 32'h0);

    // Looping source 1 preempted by source 0, then re-granted; then stop.
    i_src_done = 4'b1100;
    t = cyc;
    expect_ev(t + 2, EV_RISE, 1);
    send(8'h21);
    wait_until(t + 10);
    p = cyc;
    expect_ev(p + 1, EV_FALL, 1);
    expect_ev(p + 1003, EV_RISE, 0);
    send(8'h10);
    wait_until(p + 1008);
    q = cyc;
    expect_ev(q + 1, EV_FALL, 0);
    expect_ev(q + 1003, EV_RISE, 1);
    i_src_done[0] = 1'b1;
    tick();
    i_src_done[0] = 1'b0;
    wait_until(q + 1009);
    s = cyc;
`ifdef AUDIO_SCHED_FINISH_EN
    send(8'h00);
    wait_until(s + 4);
    check("stop_hold", 32'(o_src_enable), 32'h2);
    wait_until(s + 5);
    expect_ev(s + 6, EV_FALL, 1);
    i_src_done[1] = 1'b1;
`else
    expect_ev(s + 1, EV_FALL, 1);
    send(8'h00);
`endif
    wait_until(s + 1020);
    check("stop_no_regrant_busy", 32'(o_busy), 32'h0);
    check("stop_no_regrant_en", 32'(o_src_enable), 32'h0);

    // Command for source 1 in the same cycle as done of source 0.
    i_src_done = 4'b1110;
    t = cyc;
    expect_ev(t + 2, EV_RISE, 0);
    send(8'h10);
    wait_until(t + 4);
    send(8'h10);
    wait_until(t + 8);
    d = cyc;
    expect_ev(d + 1, EV_FALL, 0);
    expect_ev(d + 1003, EV_RISE, 1);
    expect_ev(d + 1006, EV_FALL, 1);
    i_src_done = 4'b1111;
    send(8'h11);
    wait_until(d + 1006 + GAP + 5);
    check("simul_idle", 32'(o_busy), 32'h0);

    // Asynchronous reset in the middle of a looping playback.
    i_src_done = 4'b1110;
    t = cyc;
    expect_ev(t + 2, EV_RISE, 0);
    send(8'h20);
    wait_until(t + 4);
    i_src_pulse = 4'b0001;
    wait_until(t + 6);
    check("pre_rst_pulse", 32'(o_pulse), 32'h1);
    #2 i_rst = 1'b1;
    #1;
    check("arst_enable", 32'(o_src_enable), 32'h0);
    check("arst_pulse", 32'(o_pulse), 32'h0);
    check("arst_grant", 32'(o_grant_id), 32'h0);
    check("arst_busy", 32'(o_busy), 32'h0);
    check("arst_err", 32'(o_err), 32'h0);
    repeat (3) tick();
    i_rst       = 1'b0;
    i_src_pulse = '0;
    repeat (6) tick();
    check("post_rst_busy", 32'(o_busy), 32'h0);
    check("post_rst_enable", 32'(o_src_enable), 32'h0);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_scheduler.md
AUDIO_SCHEDULER -- requirements
Module: audio_scheduler

Interface
REQ-001 SHALL have parameter N_SRC, default 4, giving the number of sound sources (2..8).
REQ-002 SHALL have parameter GAP_CYCLES, default 1000, giving the silent clocks between grants (at least 1).
REQ-003 SHALL have port i_clk, input, width 1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port i_rst, input, width 1: reset, asynchronous and active-high.
REQ-005 SHALL have port i_cmd_valid, input, width 1: one-cycle strobe from the UART receiver.
REQ-006 SHALL have port i_cmd_data, input, width 8: the command byte, sampled when i_cmd_valid=1.
REQ-007 SHALL have port i_src_pulse, input, width N_SRC: the audio pulse from each source.
REQ-008 SHALL have port i_src_done, input, width N_SRC: per-source done flag, 1 while the source is idle or finished.
REQ-009 SHALL have port o_src_enable, output, width N_SRC: per-source enable, at most one bit set.
REQ-010 SHALL have port o_pulse, output, width 1: the pulse of the granted source, registered.
REQ-011 SHALL have port o_grant_id, output, width clog2(N_SRC): the index of the granted source.
REQ-012 SHALL have port o_busy, output, width 1: 1 in states GRANT, PLAY and GAP.
REQ-013 SHALL have port o_err, output, width 1: one-cycle pulse on an invalid command.

Function
REQ-014 SHALL decode the following commands:
- 0x00: stop.
- 0x1k (k<N_SRC): one-shot request for source k.
- 0x2k (k<N_SRC): looping request for source k.
- Any other byte: o_err=1 on the next cycle; state is otherwise unchanged.
REQ-015 SHALL keep a pending bitmask and a loop bitmask; a request sets pending[k]; a looping request also sets loop[k].
REQ-016 SHALL arbitrate by fixed priority, where the lowest index wins.
REQ-017 SHALL implement FSM IDLE, GRANT, PLAY, GAP.
REQ-018 SHALL transition as follows:
- IDLE to GRANT when pending is nonzero.
- In GRANT, latch the winner into o_grant_id and clear its pending bit; if its loop bit is set, re-set the pending bit when the grant ends.
- GRANT to PLAY after exactly one cycle, with o_src_enable[grant]=1 from the first PLAY cycle.
- PLAY to GAP on the first cycle with i_src_done[grant]=1 at least 2 cycles after PLAY entry; enable drops in the GAP entry cycle.
- GAP counts GAP_CYCLES cycles, then goes to IDLE.
REQ-019 SHALL preempt in PLAY: if any pending bit with index below grant is set, go to GAP the next cycle; the preempted source is re-queued only if its loop bit is set.
REQ-020 SHALL ignore a one-shot request for the currently granted source; a looping request for it only sets loop[grant].
REQ-021 SHALL drive o_pulse = i_src_pulse[grant] delayed one cycle while in PLAY, else 0.
REQ-022 SHALL, when a command and done arrive in the same cycle, apply the command to pending/loop first; the transition from REQ-018 still occurs.
REQ-023 SHALL, on stop, clear pending and loop; the handling of the active source is set by REQ-026.
REQ-024 SHALL apply back-to-back commands on consecutive cycles in order, with none lost.

Reset
REQ-025 SHALL, while i_rst=1, immediately hold:
- state IDLE; pending and loop 0; GAP counter 0;
- o_src_enable 0, o_pulse 0, o_grant_id 0, o_busy 0, o_err 0.
A reset mid-PLAY cuts the source within the same cycle.

Configuration
REQ-026 SHALL honour macro AUDIO_SCHED_FINISH_EN:
- Defined: stop lets the granted source play until done, then GAP and IDLE.
- Undefined: stop forces PLAY to GAP the next cycle; the source is cut.

Structure
REQ-027 SHALL place the command codes (CMD_STOP=0x00, CMD_ONESHOT=0x1, CMD_LOOP=0x2 as the upper nibble), the state enum and the default N_SRC in package audio_pkg.
REQ-028 SHALL contain one sub-module, audio_prio_enc, a combinational lowest-index priority encoder with a valid output.

Verification
REQ-029 SHALL cover one-shot playback: cmd 0x10 -> enable[0]=1 two cycles after the strobe; done at cycle 50 -> enable 0, o_busy=1 for 1000 cycles, then IDLE.
REQ-030 SHALL cover preemption: looping 0x21 playing, then cmd 0x10 -> source 1 cut next cycle, GAP, source 0 plays, then source 1 is re-granted.
REQ-031 SHALL cover stop in both builds: cmd 0x00 mid-PLAY -> with the macro, enable holds until done; without it, enable 0 one cycle later; after the gap, no further grant.
REQ-032 SHALL cover invalid commands: 0x35, and 0x14 with N_SRC=4 -> o_err pulse of one cycle; pending unchanged.
REQ-033 SHALL cover async reset: i_rst asserted mid-PLAY between clock edges -> all outputs 0 with no clock edge; after release, IDLE with no grant.
REQ-034 SHALL cover simultaneity: cmd 0x11 in the same cycle as done of source 0 -> source 1 is granted after GAP.
